inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter NBITS, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory byte-address width (2**ADDR_W bytes).
REQ-003 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_rx_data  input  8  received byte from serial receiver.
REQ-006 SHALL have port i_rx_valid  input  1  one-cycle strobe, i_rx_data valid.
REQ-007 SHALL have port o_inst_mem_wr_en  output  1  instruction-memory write strobe.
REQ-008 SHALL have port o_inst_mem_addr  output  ADDR_W  byte address of the word being written.
REQ-009 SHALL have port o_inst_mem_data  output  NBITS  word being written.
REQ-010 SHALL have port o_cpu_en  output  1  pipeline clock-enable; pipeline frozen when 0.
REQ-011 SHALL have port o_load_done  output  1  high while in RUN.
REQ-012 SHALL have port o_overflow  output  1  sticky; image exceeded memory without halt word.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-014 IDLE: byte 0xA5 with i_rx_valid -> LOAD, address cleared to 0, byte counter cleared; all other bytes ignored.
REQ-015 LOAD: bytes assembled little-endian (first byte -> bits 7:0, fourth -> bits 31:24) via 2-bit byte counter.
REQ-016 On the 4th byte sampled in cycle N, o_inst_mem_wr_en SHALL be 1 for exactly cycle N+1 with o_inst_mem_addr and o_inst_mem_data stable that cycle; wr_en 0 otherwise.
REQ-017 After each write, address SHALL increment by 4, wrapping modulo 2**ADDR_W.
REQ-018 Assembled word 0xFFFFFFFF (halt) SHALL still be written, then FSM -> RUN in cycle N+2.
REQ-019 Write to the last slot (address 2**ADDR_W-4) of a non-halt word SHALL set o_overflow and move to RUN; no wrap-around write occurs.
REQ-020 Back-to-back i_rx_valid on consecutive cycles SHALL be accepted without byte loss.
REQ-021 o_cpu_en SHALL be 0 in IDLE and LOAD.
REQ-022 RUN: byte 0xA5 SHALL return to LOAD (reload), clearing address, byte counter and o_overflow; o_cpu_en drops the cycle after 0xA5 is sampled.
REQ-023 RUN: all other bytes ignored except step commands (Configuration).
REQ-024 o_load_done SHALL equal (state == RUN).

Reset
REQ-025 i_rst low at a rising edge SHALL force IDLE, address 0, byte counter 0, assembly register 0.
REQ-026 Reset values: o_inst_mem_wr_en 0, o_inst_mem_addr 0, o_inst_mem_data 0, o_cpu_en 0, o_load_done 0, o_overflow 0.
REQ-027 Reset mid-word SHALL discard partial bytes; a pending write strobe SHALL be suppressed.
REQ-028 Reset SHALL take priority over i_rx_valid in the same cycle.

Configuration
REQ-029 Macro STEP_MODE_EN SHALL enable single-step control.
REQ-030 With STEP_MODE_EN: RUN entered in step mode with o_cpu_en 0; byte 0x53 gives o_cpu_en high for exactly one cycle after sampling; byte 0x43 switches to continuous (o_cpu_en held 1); byte 0x50 returns to step mode.
REQ-031 Without STEP_MODE_EN: o_cpu_en SHALL be 1 every RUN cycle; 0x53/0x43/0x50 ignored.

Verification
REQ-032 Bytes A5,78,56,34,12,FF,FF,FF,FF -> write 0x12345678 @0, write 0xFFFFFFFF @4, then o_load_done 1, o_overflow 0.
REQ-033 Bytes 00,13,A5 then image -> 00,13 ignored, first write @0.
REQ-034 ADDR_W=4, A5 + 16 non-halt bytes -> writes @0,4,8,12, o_overflow 1, RUN, no write @0 again.
REQ-035 Reset asserted after A5,11,22 then A5,01,00,00,00,FF,FF,FF,FF -> no write of 0x..2211, write 0x00000001 @0.
REQ-036 STEP_MODE_EN: after load, send 53 -> o_cpu_en one-cycle pulse; send 43 -> o_cpu_en continuous 1; send A5 -> o_cpu_en 0, LOAD.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: serial boot loader that assembles bytes into instruction words; define STEP_MODE_EN for single-step CPU control
module inst_loader #(
    parameter int NBITS  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_inst_mem_wr_en,
    output logic [ADDR_W-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0]  o_inst_mem_data,
    output logic              o_cpu_en,
    output logic              o_load_done,
    output logic              o_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [7:0]        SYNC      = 8'hA5;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
`ifdef STEP_MODE_EN
    localparam logic [7:0]        STEP      = 8'h53;
    localparam logic [7:0]        CONT      = 8'h43;
    localparam logic [7:0]        PAUSE     = 8'h50;
`endif

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [NBITS-1:0]   word_q, word_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [NBITS-1:0]   wr_data_q, wr_data_d;
    logic               ovf_q, ovf_d;
`ifdef STEP_MODE_EN
    logic               cont_q, cont_d;
    logic               step_q, step_d;
`endif

    // Next-state logic: sync detection, little-endian byte assembly, write issue and RUN-mode commands
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
`ifdef STEP_MODE_EN
        cont_d    = cont_q;
        step_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_rx_valid && i_rx_data == SYNC) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (i_rx_valid) begin
                    word_d = {i_rx_data, word_q[NBITS-1:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_d;
                        addr_d    = addr_q + ADDR_STEP;
                    end
                end
                // The strobe cycle decides termination: halt word or last slot filled
                if (wr_en_q && ((&wr_data_q) || wr_addr_q == LAST_SLOT)) begin
                    state_d = RUN;
                    ovf_d   = ~(&wr_data_q);
                end
            end
            RUN: begin
                if (i_rx_valid && i_rx_data == SYNC) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef STEP_MODE_EN
                    cont_d  = 1'b0;
                end else if (i_rx_valid && i_rx_data == STEP) begin
                    step_d  = 1'b1;
                end else if (i_rx_valid && i_rx_data == CONT) begin
                    cont_d  = 1'b1;
                end else if (i_rx_valid && i_rx_data == PAUSE) begin
                    cont_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset also cancels any pending write strobe
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
`ifdef STEP_MODE_EN
            cont_q    <= 1'b0;
            step_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
`ifdef STEP_MODE_EN
            cont_q    <= cont_d;
            step_q    <= step_d;
`endif
        end
    end

    assign o_inst_mem_wr_en = wr_en_q;
    assign o_inst_mem_addr  = wr_addr_q;
    assign o_inst_mem_data  = wr_data_q;
    assign o_load_done      = (state_q == RUN);
    assign o_overflow       = ovf_q;
`ifdef STEP_MODE_EN
    assign o_cpu_en         = (state_q == RUN) && (cont_q || step_q);
`else
    assign o_cpu_en         = (state_q == RUN);
`endif

endmodule
